// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- serial-to-parallel UART receiver, 8 data bits, LSB first.
//
// Detects a start bit on serial_i and samples each bit in the middle of its
// window using a baud divider that is latched at start detect. The stop bit is
// checked. A good byte lands in a single-entry holding register that the host
// consumes with a rising edge on ack_i.
//
// Optional feature: define UART_RX_PARITY_EN to compile in the PARITY state
// and parity checking. Without it, frames are always 8N1 and parity_bit_i /
// parity_even_i are ignored.
//
// Ports:
//   clock_i          in   1   system clock
//   reset_i          in   1   asynchronous active-low reset
//   ack_i            in   1   host acknowledge; a rising edge consumes the byte
//   parity_bit_i     in   1   1 = frame carries a parity bit after the data
//   parity_even_i    in   1   1 = even parity, 0 = odd parity
//   serial_i         in   1   serial line, idle high, already synchronized
//   clock_divider_i  in  16   clocks per bit; 0 and 1 behave as 2
//   data_o           out  8   last accepted byte
//   ready_o          out  1   data_o holds an unconsumed byte
// ---------------------------------------------------------------------------
module uart_rx (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        ack_i,
    input  logic        parity_bit_i,
    input  logic        parity_even_i,
    input  logic        serial_i,
    input  logic [15:0] clock_divider_i,
    output logic [7:0]  data_o,
    output logic        ready_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state;
    logic [15:0] div;        // divider frozen for the current frame
    logic [15:0] cnt;        // cycle position relative to the last sample
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        bad;        // frame already known to be unusable
    logic        ack_prev;

    logic [15:0] div_eff;
    logic [15:0] half;
    logic        ack_rise;

`ifdef UART_RX_PARITY_EN
    logic        par_en;
    logic        par_even;
`else
    logic        unused_parity;
    assign unused_parity = parity_bit_i ^ parity_even_i;
`endif

    assign div_eff  = (clock_divider_i < 16'd2) ? 16'd2 : clock_divider_i;
    assign half     = div >> 1;
    assign ack_rise = ack_i & ~ack_prev;

    // cnt is loaded with 1 at start detect, so the START sample lands on cycle
    // floor(D/2); every later sample is exactly D cycles after the previous.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state    <= IDLE;
            div      <= 16'd2;
            cnt      <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
            bad      <= 1'b0;
            ack_prev <= 1'b0;
            data_o   <= 8'h00;
            ready_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en   <= 1'b0;
            par_even <= 1'b0;
`endif
        end else begin
            ack_prev <= ack_i;
            // An acceptance later in this block overrides this clear, which
            // gives the new byte priority over a simultaneous ack edge.
            if (ack_rise) begin
                ready_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!serial_i) begin
                        div     <= div_eff;
                        cnt     <= 16'd1;
                        bit_idx <= 3'd0;
                        bad     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_en   <= parity_bit_i;
                        par_even <= parity_even_i;
`endif
                        state   <= START;
                    end
                end

                START: begin
                    if (cnt == half) begin
                        cnt   <= 16'd1;
                        // A high mid-start sample is a glitch, not a frame.
                        state <= serial_i ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (cnt == div) begin
                        cnt     <= 16'd1;
                        shift   <= {serial_i, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= par_en ? PARITY : STOP;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == div) begin
                        cnt   <= 16'd1;
                        // Even parity expects the XOR of the data bits;
                        // odd parity expects its inverse.
                        if (serial_i != ((^shift) ^ ~par_even)) begin
                            bad <= 1'b1;
                        end
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`endif

                STOP: begin
                    if (cnt == div) begin
                        cnt   <= 16'd0;
                        // Leave at the stop sample so a back-to-back start
                        // bit is seen on the very next edge.
                        state <= IDLE;
                        if (serial_i && !bad && (!ready_o || ack_rise)) begin
                            data_o  <= shift;
                            ready_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx: basic receive, ack handshake,
// overrun, parity (when UART_RX_PARITY_EN is defined), framing error, start
// glitch, divider clamping and asynchronous reset mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    logic        clock_i;
    logic        reset_i;
    logic        ack_i;
    logic        parity_bit_i;
    logic        parity_even_i;
    logic        serial_i;
    logic [15:0] clock_divider_i;
    logic [7:0]  data_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    uart_rx dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .ack_i           (ack_i),
        .parity_bit_i    (parity_bit_i),
        .parity_even_i   (parity_even_i),
        .serial_i        (serial_i),
        .clock_divider_i (clock_divider_i),
        .data_o          (data_o),
        .ready_o         (ready_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one frame; each bit occupies 'len' clock cycles. Starts and ends
    // on a falling clock edge.
    task automatic send(input logic [7:0] b, input int len, input logic par_on,
                        input logic par_val, input logic stop_val);
        serial_i = 1'b0;
        repeat (len) @(negedge clock_i);
        for (int i = 0; i < 8; i++) begin
            serial_i = b[i];
            repeat (len) @(negedge clock_i);
        end
        if (par_on) begin
            serial_i = par_val;
            repeat (len) @(negedge clock_i);
        end
        serial_i = stop_val;
        repeat (len) @(negedge clock_i);
        serial_i = 1'b1;
        repeat (3) @(negedge clock_i);
    endtask

    task automatic ack_pulse();
        ack_i = 1'b1;
        @(negedge clock_i);
        ack_i = 1'b0;
        @(negedge clock_i);
    endtask

    initial begin
        reset_i         = 1'b0;
        ack_i           = 1'b0;
        parity_bit_i    = 1'b0;
        parity_even_i   = 1'b1;
        serial_i        = 1'b1;
        clock_divider_i = 16'd2;
        repeat (3) @(negedge clock_i);
        check("reset_ready", {7'd0, ready_o}, 8'h00);
        check("reset_data", data_o, 8'h00);

        reset_i = 1'b1;
        repeat (2) @(negedge clock_i);

        // Basic receive at D = 2
        send(8'h55, 2, 1'b0, 1'b0, 1'b1);
        check("basic_ready", {7'd0, ready_o}, 8'h01);
        check("basic_data", data_o, 8'h55);

        // Ack rising edge clears ready on the next edge
        ack_i = 1'b1;
        @(negedge clock_i);
        check("ack_clear", {7'd0, ready_o}, 8'h00);

        // Ack held high: a new byte is still accepted
        send(8'hAA, 2, 1'b0, 1'b0, 1'b1);
        check("held_ack_ready", {7'd0, ready_o}, 8'h01);
        check("held_ack_data", data_o, 8'hAA);

        // Overrun: byte dropped while ready is set
        send(8'hCC, 2, 1'b0, 1'b0, 1'b1);
        check("overrun_data", data_o, 8'hAA);
        check("overrun_ready", {7'd0, ready_o}, 8'h01);

        ack_i = 1'b0;
        repeat (2) @(negedge clock_i);
        check("ack_fall_ready", {7'd0, ready_o}, 8'h01);
        ack_pulse();
        check("ack_pulse_clear", {7'd0, ready_o}, 8'h00);

        // Framing error: stop bit held low
        send(8'h12, 2, 1'b0, 1'b0, 1'b0);
        check("framing_ready", {7'd0, ready_o}, 8'h00);
        check("framing_data", data_o, 8'hAA);

        // One-cycle low glitch at D = 8
        clock_divider_i = 16'd8;
        serial_i = 1'b0;
        @(negedge clock_i);
        serial_i = 1'b1;
        repeat (100) @(negedge clock_i);
        check("glitch_ready", {7'd0, ready_o}, 8'h00);

        // Good frame at D = 8
        send(8'h81, 8, 1'b0, 1'b0, 1'b1);
        check("d8_ready", {7'd0, ready_o}, 8'h01);
        check("d8_data", data_o, 8'h81);
        ack_pulse();

        // Divider 0 behaves as 2
        clock_divider_i = 16'd0;
        send(8'h5A, 2, 1'b0, 1'b0, 1'b1);
        check("div0_ready", {7'd0, ready_o}, 8'h01);
        check("div0_data", data_o, 8'h5A);
        clock_divider_i = 16'd2;

        // Asynchronous reset in the middle of a frame
        serial_i = 1'b0;
        repeat (5) @(negedge clock_i);
        #2 reset_i = 1'b0;
        #1;
        check("async_reset_ready", {7'd0, ready_o}, 8'h00);
        check("async_reset_data", data_o, 8'h00);
        @(negedge clock_i);
        serial_i = 1'b1;
        @(negedge clock_i);
        reset_i = 1'b1;
        repeat (2) @(negedge clock_i);
        send(8'h3C, 2, 1'b0, 1'b0, 1'b1);
        check("post_reset_ready", {7'd0, ready_o}, 8'h01);
        check("post_reset_data", data_o, 8'h3C);
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        // Even parity: 8'h07 has three ones, so the parity bit must be 1
        parity_bit_i  = 1'b1;
        parity_even_i = 1'b1;
        send(8'h07, 2, 1'b1, 1'b1, 1'b1);
        check("parity_good_ready", {7'd0, ready_o}, 8'h01);
        check("parity_good_data", data_o, 8'h07);
        ack_pulse();
        send(8'h07, 2, 1'b1, 1'b0, 1'b1);
        check("parity_bad_ready", {7'd0, ready_o}, 8'h00);
        parity_bit_i = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
